frame_stream_reader: RTL and testbench

- Read-side scanner for the camera frame buffer.
- On a start pulse, walks every pixel address in raster order through one synchronous read port (1-cycle read latency).
- Presents the pixels as a valid/ready stream with x/y coordinates and frame/line markers.
- Feeds the downstream image-processing pipeline (grayscale/edge/plotter path) and absorbs its backpressure without losing or duplicating pixels.

---
 rtl/frame_stream_reader.sv | 155 +++++++++++++++
 tb/tb_frame_stream_reader.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_reader.sv
// Raster-order frame buffer scanner: issues one read per free FIFO slot,
// captures the 1-cycle-latency read data with its coordinates/markers into a
// 2-entry FIFO, and presents the FIFO head as a valid/ready pixel stream.
module frame_stream_reader #(
  parameter int RGB_WIDTH    = 24,
  parameter int IMG_WIDTH    = 176,
  parameter int IMG_HEIGHT   = 240,
  parameter int TOTAL_PIXELS = IMG_WIDTH * IMG_HEIGHT,
  parameter int ADDR_WIDTH   = (TOTAL_PIXELS > 1) ? $clog2(TOTAL_PIXELS) : 1,
  parameter int X_WIDTH      = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1,
  parameter int Y_WIDTH      = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  oe,
  output logic [ADDR_WIDTH-1:0] rAddr,
  input  logic [RGB_WIDTH-1:0]  rData,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [RGB_WIDTH-1:0]  m_data,
  output logic [X_WIDTH-1:0]    m_x,
  output logic [Y_WIDTH-1:0]    m_y,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof
);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_DONE} state_t;

  // FIFO entry layout: {sof, eol, eof, y, x, data}
  localparam int unsigned MW = X_WIDTH + Y_WIDTH + 3;
  localparam int unsigned EW = RGB_WIDTH + MW;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(TOTAL_PIXELS - 1);
  localparam logic [X_WIDTH-1:0]    X_LAST    = X_WIDTH'(IMG_WIDTH - 1);
  localparam logic [Y_WIDTH-1:0]    Y_LAST    = Y_WIDTH'(IMG_HEIGHT - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [X_WIDTH-1:0]    r_x;
  logic [Y_WIDTH-1:0]    r_y;
  logic                  r_inflight;
  logic [MW-1:0]         r_inflight_meta;
  logic [EW-1:0]         r_fifo [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;

  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_valid;
  logic                  w_last_addr;
  logic [1:0]            w_count_next;
  logic [MW-1:0]         w_issue_meta;
  logic [EW-1:0]         w_head;

  assign w_last_addr  = (r_addr == ADDR_LAST);
  assign w_valid      = (r_count != 2'd0);
  // A read is issued only if the FIFO can hold it together with any read already in flight.
  assign w_issue      = (r_state == ST_SCAN) && ((r_count + {1'b0, r_inflight}) < 2'd2);
  assign w_push       = r_inflight;
  assign w_pop        = w_valid && m_ready;
  assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_issue_meta = {(r_addr == '0), (r_x == X_LAST), w_last_addr, r_y, r_x};
  assign w_head       = r_fifo[r_rptr];

  assign oe      = w_issue;
  assign rAddr   = r_addr;
  assign busy    = (r_state == ST_SCAN) || (r_state == ST_DRAIN);
  assign done    = (r_state == ST_DONE);
  assign m_valid = w_valid;
  assign m_data  = w_head[RGB_WIDTH-1:0];
  assign m_x     = w_head[RGB_WIDTH +: X_WIDTH];
  assign m_y     = w_head[RGB_WIDTH + X_WIDTH +: Y_WIDTH];
  assign m_eof   = w_valid & w_head[EW-3];
  assign m_eol   = w_valid & w_head[EW-2];
  assign m_sof   = w_valid & w_head[EW-1];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; DRAIN exits on the cycle the last entry is popped so
  // done follows the final accept by exactly one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_SCAN;
      ST_SCAN:  if (w_issue && w_last_addr) w_state_next = ST_DRAIN;
      ST_DRAIN: if (!r_inflight && (w_count_next == 2'd0)) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Raster address and coordinate counters, advanced per issued read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
      r_x    <= '0;
      r_y    <= '0;
    end else if (w_issue) begin
      if (!w_last_addr) r_addr <= r_addr + ADDR_WIDTH'(1);
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? '0 : r_y + Y_WIDTH'(1);
      end else begin
        r_x <= r_x + X_WIDTH'(1);
      end
    end else if (r_state == ST_DONE) begin
      r_addr <= '0;
      r_x    <= '0;
      r_y    <= '0;
    end
  end

  // Tracks the outstanding read and the coordinates/markers it was issued with.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight      <= 1'b0;
      r_inflight_meta <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflight_meta <= w_issue_meta;
    end
  end

  // Two-entry output FIFO; push captures read data, pop on stream transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) r_fifo[i] <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= {r_inflight_meta, rData};
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= w_count_next;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(w_push && (r_count == 2'd2)));

endmodule

// File: tb/tb_frame_stream_reader.sv
// Scoreboard bench: a reduced-size main instance (8x5) checked by a monitor
// against a queue of expected pixels, plus a 4x2 instance checked directly.
module tb_frame_stream_reader;

  localparam int TB_W   = 8;
  localparam int TB_H   = 5;
  localparam int TB_TOT = TB_W * TB_H;

  typedef struct packed {
    logic [23:0] data;
    logic [2:0]  x;
    logic [2:0]  y;
    logic        sof;
    logic        eol;
    logic        eof;
  } pix_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy, done, oe;
  logic [5:0]  rAddr;
  logic [23:0] rData;
  logic        m_valid, m_ready;
  logic [23:0] m_data;
  logic [2:0]  m_x, m_y;
  logic        m_sof, m_eol, m_eof;

  logic        s_start;
  logic        s_busy, s_done, s_oe;
  logic [2:0]  s_rAddr;
  logic [23:0] s_rData;
  logic        s_m_valid, s_m_ready;
  logic [23:0] s_m_data;
  logic [1:0]  s_m_x;
  logic [0:0]  s_m_y;
  logic        s_m_sof, s_m_eol, s_m_eof;

  int   checks;
  int   failures;
  int   cyc;
  pix_t sb[$];
  int   rx_idx;
  int   exp_addr;
  int   outstanding;
  int   done_cnt;
  int   last_acc;
  logic rand_ready;
  logic fix_ready;

  assign s_m_ready = 1'b1;

  frame_stream_reader #(
    .RGB_WIDTH (24),
    .IMG_WIDTH (TB_W),
    .IMG_HEIGHT(TB_H)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .oe(oe), .rAddr(rAddr), .rData(rData), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_x(m_x), .m_y(m_y),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
  );

  frame_stream_reader #(
    .RGB_WIDTH (24),
    .IMG_WIDTH (4),
    .IMG_HEIGHT(2)
  ) u_small (
    .clk(clk), .reset(reset), .start(s_start), .busy(s_busy), .done(s_done),
    .oe(s_oe), .rAddr(s_rAddr), .rData(s_rData), .m_valid(s_m_valid),
    .m_ready(s_m_ready), .m_data(s_m_data), .m_x(s_m_x), .m_y(s_m_y),
    .m_sof(s_m_sof), .m_eol(s_m_eol), .m_eof(s_m_eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame buffer models: data = address, one-cycle read latency.
  always @(posedge clk) if (oe) rData <= 24'(rAddr);
  always @(posedge clk) if (s_oe) s_rData <= 24'(s_rAddr);

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Downstream ready: fixed level or 50% random, updated just after each edge.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? ($urandom_range(0, 1) == 1) : fix_ready;
    end
  end

  // Monitor: read-issue rules, stream contents against the scoreboard, done timing.
  initial begin
    pix_t     got;
    logic [8:0] fl;
    outstanding = 0;
    exp_addr    = 0;
    rx_idx      = 0;
    done_cnt    = 0;
    last_acc    = -10;
    forever begin
      @(negedge clk);
      if (reset) begin
        outstanding = 0;
        exp_addr    = 0;
        rx_idx      = 0;
      end else begin
        if (oe) begin
          checks = checks + 1;
          if (outstanding >= 2) begin
            failures = failures + 1;
            $display("FAIL oe_credit outstanding=%0d required<2", outstanding);
          end
          checks = checks + 1;
          if (int'(rAddr) != exp_addr) begin
            failures = failures + 1;
            $display("FAIL raddr got=%0d exp=%0d", rAddr, exp_addr);
          end
          exp_addr = exp_addr + 1;
        end
        if (m_valid) begin
          got = {m_data, m_x, m_y, m_sof, m_eol, m_eof};
          checks = checks + 1;
          if (sb.size() == 0) begin
            failures = failures + 1;
            $display("FAIL unexpected_valid got=%h exp=none", got);
          end else if (got != sb[0]) begin
            failures = failures + 1;
            $display("FAIL pixel idx=%0d got=%h exp=%h", rx_idx, got, sb[0]);
          end
          if (m_ready && sb.size() != 0) begin
            fl = {m_x, m_y, m_sof, m_eol, m_eof};
            if (rx_idx == 0 || rx_idx == 7 || rx_idx == 8 || rx_idx == 39) begin
              checks = checks + 1;
              case (rx_idx)
                0:  if (fl != {3'd0, 3'd0, 1'b1, 1'b0, 1'b0} || m_data != 24'd0) begin
                      failures = failures + 1;
                      $display("FAIL first_pixel got=%b data=%0d exp=000000100 data=0", fl, m_data);
                    end
                7:  if (fl != {3'd7, 3'd0, 1'b0, 1'b1, 1'b0}) begin
                      failures = failures + 1;
                      $display("FAIL line_end got=%b exp=111000010", fl);
                    end
                8:  if (fl != {3'd0, 3'd1, 1'b0, 1'b0, 1'b0}) begin
                      failures = failures + 1;
                      $display("FAIL line_start got=%b exp=000001000", fl);
                    end
                default: if (fl != {3'd7, 3'd4, 1'b0, 1'b1, 1'b1}) begin
                      failures = failures + 1;
                      $display("FAIL frame_end got=%b exp=111100011", fl);
                    end
              endcase
            end
            if (m_eof) last_acc = cyc;
            void'(sb.pop_front());
            rx_idx = rx_idx + 1;
          end
        end
        if (done) begin
          checks = checks + 1;
          if (cyc != last_acc + 1) begin
            failures = failures + 1;
            $display("FAIL done_latency got_cycle=%0d exp_cycle=%0d", cyc, last_acc + 1);
          end
          done_cnt = done_cnt + 1;
          rx_idx   = 0;
          exp_addr = 0;
        end
        outstanding = outstanding + (oe ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push_frame();
    pix_t p;
    for (int a = 0; a < TB_TOT; a++) begin
      p.data = 24'(a);
      p.x    = 3'(a % TB_W);
      p.y    = 3'(a / TB_W);
      p.sof  = (a == 0);
      p.eol  = ((a % TB_W) == TB_W - 1);
      p.eof  = (a == TB_TOT - 1);
      sb.push_back(p);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_rx(input string name, input int n);
    int i;
    i = 0;
    while (rx_idx < n && i < 1000) begin
      @(posedge clk);
      i = i + 1;
    end
    if (rx_idx < n) chk(name, 64'(rx_idx), 64'(n));
  endtask

  task automatic wait_done(input string name);
    int d0;
    int i;
    d0 = done_cnt;
    i  = 0;
    while (done_cnt == d0 && i < 3000) begin
      @(posedge clk);
      i = i + 1;
    end
    if (done_cnt == d0) chk({name, "_timeout"}, 64'(i), 64'(0));
    repeat (3) @(negedge clk);
    #1;
    chk({name, "_done_once"}, 64'(done_cnt), 64'(d0 + 1));
    chk({name, "_busy_low"}, 64'(busy), 64'(0));
    chk({name, "_sb_empty"}, 64'(sb.size()), 64'(0));
  endtask

  logic [5:0] s_tab [8];

  initial begin
    int k;
    int s_last;
    int s_dones;
    checks     = 0;
    failures   = 0;
    start      = 1'b0;
    s_start    = 1'b0;
    rand_ready = 1'b0;
    fix_ready  = 1'b1;
    // {x, y, sof, eol, eof} for the 4x2 build
    s_tab[0] = {2'd0, 1'd0, 1'b1, 1'b0, 1'b0};
    s_tab[1] = {2'd1, 1'd0, 1'b0, 1'b0, 1'b0};
    s_tab[2] = {2'd2, 1'd0, 1'b0, 1'b0, 1'b0};
    s_tab[3] = {2'd3, 1'd0, 1'b0, 1'b1, 1'b0};
    s_tab[4] = {2'd0, 1'd1, 1'b0, 1'b0, 1'b0};
    s_tab[5] = {2'd1, 1'd1, 1'b0, 1'b0, 1'b0};
    s_tab[6] = {2'd2, 1'd1, 1'b0, 1'b0, 1'b0};
    s_tab[7] = {2'd3, 1'd1, 1'b0, 1'b1, 1'b1};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_state",
        64'({busy, done, oe, m_valid, m_sof, m_eol, m_eof, rAddr, m_data, m_x, m_y}),
        64'(0));

    // Full frame, ready held high.
    fix_ready = 1'b1;
    push_frame();
    pulse_start();
    wait_done("frame_ready");

    // Full frame under random backpressure.
    rand_ready = 1'b1;
    push_frame();
    pulse_start();
    wait_done("frame_random");

    // Second start while busy must be ignored.
    push_frame();
    pulse_start();
    wait_rx("restart_wait", 10);
    pulse_start();
    wait_done("start_busy");

    // Reset mid-frame with downstream stalled and FIFO full.
    rand_ready = 1'b0;
    fix_ready  = 1'b1;
    push_frame();
    pulse_start();
    wait_rx("abort_wait", 20);
    fix_ready = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("stall_valid", 64'(m_valid), 64'(1));
    chk("stall_no_oe", 64'(oe), 64'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_state", 64'({m_valid, busy, rAddr}), 64'(0));
    fix_ready = 1'b1;
    push_frame();
    pulse_start();
    wait_done("after_abort");

    // Small 4x2 build, ready tied high.
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    k       = 0;
    s_last  = -10;
    s_dones = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_m_valid) begin
        if (k < 8) begin
          chk("small_pixel", 64'({s_m_data, s_m_x, s_m_y, s_m_sof, s_m_eol, s_m_eof}),
              64'({24'(k), s_tab[k]}));
        end
        k      = k + 1;
        s_last = cyc;
      end
      if (s_done) begin
        s_dones = s_dones + 1;
        chk("small_done_latency", 64'(cyc), 64'(s_last + 1));
      end
    end
    chk("small_count", 64'(k), 64'(8));
    chk("small_done_once", 64'(s_dones), 64'(1));
    chk("small_busy_low", 64'(s_busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
